// File: rtl/uartb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uartb_pkg
//  Description : Shared types and constants for the uartb burst UART core:
//                TX/RX state encodings, config-word bit positions and the
//                8N1 frame shape.
//  Revision    : 1.0  initial release
// ============================================================================
package uartb_pkg;

  // Config word layout (divider occupies the low DIV_W bits)
  localparam int CFG_BURST_BIT = 31;
  localparam int CFG_LPBK_BIT  = 30;

  // Frame shape: 8 data bits, 1 stop bit, 4 bytes per burst word
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uartb_burst_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : uartb_burst_core_if
//  Description : CPU peripheral-bus side of the burst UART.
//                master (CPU) drives d/wrtx/wrbaud/rd and observes
//                q/dv/fe/ove/thre/tend; slave is the UART core.
//  Revision    : 1.0  initial release
// ============================================================================
interface uartb_burst_core_if;
  logic [31:0] d;       // write data (TX word or config word)
  logic        wrtx;    // one-cycle TX write strobe
  logic        wrbaud;  // one-cycle config write strobe
  logic        rd;      // one-cycle RX read/acknowledge strobe
  logic [7:0]  q;       // last received byte
  logic        dv;      // received byte valid
  logic        fe;      // framing error of byte in q
  logic        ove;     // overrun
  logic        thre;    // TX holding register empty
  logic        tend;    // transmitter fully idle

  modport master (
    output d, wrtx, wrbaud, rd,
    input  q, dv, fe, ove, thre, tend
  );

  modport slave (
    input  d, wrtx, wrbaud, rd,
    output q, dv, fe, ove, thre, tend
  );
endinterface
`default_nettype wire

// File: rtl/uartb_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uartb_rx
//  Description : 8N1 receiver. 2-flop synchronizer, start-bit qualification
//                at half bit, mid-bit sampling of data and stop, and the
//                q/dv/fe/ove result registers.
//  Ports       : clk, resetb (sync, active low)
//                rx_in      serial input (asynchronous)
//                div        bit period minus one, in clk cycles
//                rd         acknowledge strobe, clears dv/fe/ove
//                q/dv/fe/ove received byte and status
//  Revision    : 1.0  initial release
// ============================================================================
module uartb_rx #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             rx_in,
  input  logic [DIV_W-1:0] div,
  input  logic             rd,
  output logic [7:0]       q,
  output logic             dv,
  output logic             fe,
  output logic             ove
);
  import uartb_pkg::*;

  logic [1:0]       r_sync;
  logic             r_prev;
  rx_state_t        r_state;
  logic [DIV_W-1:0] r_tmr;
  logic [2:0]       r_bits;
  logic [7:0]       r_sh;
  logic [7:0]       r_q;
  logic             r_dv;
  logic             r_fe;
  logic             r_ove;

  logic             w_rx;
  logic [DIV_W-1:0] w_start_ld;

  assign w_rx = r_sync[1];

  // Start-bit check lands at (div+1)/2 clocks after the synchronized edge.
  // Edge detection already costs one clock and the countdown adds one more,
  // hence the "-2"; small dividers saturate at zero.
  assign w_start_ld = (div >= DIV_W'(3))
                    ? ((div >> 1) - DIV_W'(2) + {{(DIV_W-1){1'b0}}, div[0]})
                    : '0;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_tmr   <= '0;
      r_bits  <= '0;
      r_sh    <= '0;
      r_q     <= '0;
      r_dv    <= 1'b0;
      r_fe    <= 1'b0;
      r_ove   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx_in};
      r_prev <= w_rx;

      if (rd) begin
        r_dv  <= 1'b0;
        r_fe  <= 1'b0;
        r_ove <= 1'b0;
      end

      case (r_state)
        RX_IDLE: begin
          if (r_prev && !w_rx) begin
            r_state <= RX_START;
            r_tmr   <= w_start_ld;
          end
        end
        RX_START: begin
          if (r_tmr == '0) begin
            if (w_rx) begin
              r_state <= RX_IDLE;       // glitch, not a real start bit
            end else begin
              r_state <= RX_DATA;
              r_tmr   <= div;
              r_bits  <= '0;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        RX_DATA: begin
          if (r_tmr == '0) begin
            r_sh   <= {w_rx, r_sh[7:1]};
            r_tmr  <= div;
            r_bits <= r_bits + 1'b1;
            if (r_bits == 3'(DATA_BITS - 1)) begin
              r_state <= RX_STOP;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        RX_STOP: begin
          if (r_tmr == '0) begin
            // New byte wins over a same-cycle rd; overrun only counts an
            // unacknowledged previous byte.
            r_q     <= r_sh;
            r_dv    <= 1'b1;
            r_fe    <= ~w_rx;
            r_ove   <= (r_ove | r_dv) & ~rd;
            r_state <= RX_IDLE;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign q   = r_q;
  assign dv  = r_dv;
  assign fe  = r_fe;
  assign ove = r_ove;

endmodule
`default_nettype wire

// File: rtl/uartb_burst_core.sv
`default_nettype none
// ============================================================================
//  Module      : uartb_burst_core
//  Description : 8N1 UART with programmable baud divider and 32-bit
//                word-burst transmit (4 bytes, LSB byte first).
//  Ports       : clk, resetb (sync, active low)
//                bus   uartb_burst_core_if.slave (d, wrtx, wrbaud, rd,
//                      q, dv, fe, ove, thre, tend)
//                rxd   serial input pin, txd serial output pin (idle high)
//  Options     : UARTB_LOOPBACK_EN - config bit 30 selects internal txd as
//                the receiver input.
//  Revision    : 1.0  initial release
// ============================================================================
module uartb_burst_core #(
  parameter int DIV_W = 16
) (
  input  logic               clk,
  input  logic               resetb,
  uartb_burst_core_if.slave  bus,
  input  logic               rxd,
  output logic               txd
);
  import uartb_pkg::*;

  // ---------------------------------------------------------------- config
  logic [DIV_W-1:0] r_div;
  logic             r_burst;
  logic             w_rx_in;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_div   <= '0;
      r_burst <= 1'b0;
    end else if (bus.wrbaud) begin
      r_div   <= bus.d[DIV_W-1:0];
      r_burst <= bus.d[CFG_BURST_BIT];
    end
  end

  // ---------------------------------------------------------------- TX
  // The holding register keeps the whole word; r_hold_cnt counts bytes not
  // yet moved into the shifter, so thre frees up as the last byte leaves.
  logic [31:0]      r_hold;
  logic [2:0]       r_hold_cnt;
  logic [1:0]       r_hold_idx;
  tx_state_t        r_tx_state;
  logic [DIV_W-1:0] r_tx_tmr;
  logic [2:0]       r_tx_bits;
  logic [7:0]       r_tx_sh;
  logic             r_txd;

  logic             w_thre;
  logic             w_load;
  logic [7:0]       w_next_byte;

  assign w_thre = (r_hold_cnt == 3'd0);

  // Load a byte when idle, or straight out of a finishing stop bit so burst
  // bytes follow each other with no idle gap.
  assign w_load = !w_thre &&
                  ((r_tx_state == TX_IDLE) ||
                   ((r_tx_state == TX_STOP) && (r_tx_tmr == '0)));

  always_comb begin
    w_next_byte = r_hold[7:0];
    case (r_hold_idx)
      2'd1:    w_next_byte = r_hold[15:8];
      2'd2:    w_next_byte = r_hold[23:16];
      2'd3:    w_next_byte = r_hold[31:24];
      default: w_next_byte = r_hold[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_hold     <= '0;
      r_hold_cnt <= 3'd0;
      r_hold_idx <= 2'd0;
      r_tx_state <= TX_IDLE;
      r_tx_tmr   <= '0;
      r_tx_bits  <= '0;
      r_tx_sh    <= '0;
      r_txd      <= 1'b1;
    end else begin
      // Byte count is fixed by the mode current at write time.
      if (bus.wrtx && w_thre) begin
        r_hold     <= bus.d;
        r_hold_cnt <= r_burst ? 3'(WORD_BYTES) : 3'd1;
        r_hold_idx <= 2'd0;
      end

      case (r_tx_state)
        TX_IDLE: begin
          r_txd <= 1'b1;
        end
        TX_START: begin
          if (r_tx_tmr == '0) begin
            r_tx_state <= TX_DATA;
            r_txd      <= r_tx_sh[0];
            r_tx_bits  <= '0;
            r_tx_tmr   <= r_div;
          end else begin
            r_tx_tmr <= r_tx_tmr - 1'b1;
          end
        end
        TX_DATA: begin
          if (r_tx_tmr == '0) begin
            r_tx_tmr <= r_div;
            if (r_tx_bits == 3'(DATA_BITS - 1)) begin
              r_tx_state <= TX_STOP;
              r_txd      <= 1'b1;
            end else begin
              r_tx_sh   <= r_tx_sh >> 1;
              r_txd     <= r_tx_sh[1];
              r_tx_bits <= r_tx_bits + 1'b1;
            end
          end else begin
            r_tx_tmr <= r_tx_tmr - 1'b1;
          end
        end
        TX_STOP: begin
          if (r_tx_tmr == '0) begin
            r_tx_state <= TX_IDLE;
            r_txd      <= 1'b1;
          end else begin
            r_tx_tmr <= r_tx_tmr - 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase

      // Overrides the STOP->IDLE transition above when another byte waits.
      if (w_load) begin
        r_tx_sh    <= w_next_byte;
        r_txd      <= 1'b0;
        r_tx_tmr   <= r_div;
        r_tx_state <= TX_START;
        r_hold_cnt <= r_hold_cnt - 3'd1;
        r_hold_idx <= r_hold_idx + 2'd1;
      end
    end
  end

  assign txd      = r_txd;
  assign bus.thre = w_thre;
  assign bus.tend = (r_tx_state == TX_IDLE) && w_thre;

  // ---------------------------------------------------------------- RX
`ifdef UARTB_LOOPBACK_EN
  logic r_lpbk;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_lpbk <= 1'b0;
    end else if (bus.wrbaud) begin
      r_lpbk <= bus.d[CFG_LPBK_BIT];
    end
  end

  assign w_rx_in = r_lpbk ? r_txd : rxd;
`else
  assign w_rx_in = rxd;
`endif

  uartb_rx #(
    .DIV_W (DIV_W)
  ) u_rx (
    .clk    (clk),
    .resetb (resetb),
    .rx_in  (w_rx_in),
    .div    (r_div),
    .rd     (bus.rd),
    .q      (bus.q),
    .dv     (bus.dv),
    .fe     (bus.fe),
    .ove    (bus.ove)
  );

endmodule
`default_nettype wire

// File: tb/tb_uartb_burst_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uartb_burst_core
//  Description : Self-checking bench for uartb_burst_core. A serial decoder
//                on txd and byte queues act as the reference; rxd is either
//                wired to txd or driven by a bench serializer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uartb_burst_core;

  localparam int LIM = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb;
  logic rxd_drv;
  logic lb;
  logic txd;
  logic rxd_w;

  assign rxd_w = lb ? txd : rxd_drv;

  uartb_burst_core_if bus ();

  uartb_burst_core #(.DIV_W(16)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus),
    .rxd    (rxd_w),
    .txd    (txd)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  int cur_div   = 0;
  bit cur_burst = 0;

  typedef struct {
    logic [7:0] b;
    bit         b2b;   // must start exactly one frame after previous byte
  } txb_t;

  txb_t       tx_exp[$];
  logic [7:0] rx_exp[$];

  typedef struct {
    logic [7:0] b;
    bit         stop;
    logic [7:0] exp_q;
    bit         exp_fe;
  } rxvec_t;

  rxvec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_vec++;
    if (v < lo || v > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic write_cfg(input logic [31:0] v);
    @(negedge clk);
    bus.d      = v;
    bus.wrbaud = 1'b1;
    @(negedge clk);
    bus.wrbaud = 1'b0;
    cur_div    = int'(v[15:0]);
    cur_burst  = v[31];
  endtask

  task automatic push_word(input logic [31:0] w, input bit burst);
    txb_t e;
    int   n;
    n = burst ? 4 : 1;
    for (int i = 0; i < n; i++) begin
      e.b   = w[8*i +: 8];
      e.b2b = (i != 0);
      tx_exp.push_back(e);
      rx_exp.push_back(e.b);
    end
  endtask

  task automatic write_tx(input logic [31:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.thre !== 1'b1 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIM) begin
      n_vec++; n_err++;
      $display("FAIL thre_wait: got timeout, expected thre=1");
    end
    bus.d    = w;
    bus.wrtx = 1'b1;
    push_word(w, cur_burst);
    @(negedge clk);
    bus.wrtx = 1'b0;
  endtask

  // Reference decoder of the txd pin: mid-bit sampling of 10-bit frames.
  task automatic mon_tx(input int n);
    int         t;
    int         p;
    int         st;
    int         prev_st;
    logic [7:0] b;
    txb_t       e;
    prev_st = 0;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (txd !== 1'b0 && t < LIM) begin
        @(negedge clk);
        t++;
      end
      if (t >= LIM) begin
        n_vec++; n_err++;
        $display("FAIL tx_start: got timeout, expected start bit");
        return;
      end
      st = cyc;
      p  = cur_div + 1;
      repeat (p / 2) @(negedge clk);
      check("tx_start_bit", txd, 1'b0);
      for (int k = 0; k < 8; k++) begin
        repeat (p) @(negedge clk);
        b[k] = txd;
      end
      repeat (p) @(negedge clk);
      check("tx_stop_bit", txd, 1'b1);
      if (tx_exp.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL tx_extra: got byte 0x%0h, expected none", b);
      end else begin
        e = tx_exp.pop_front();
        check("tx_byte", b, e.b);
        if (e.b2b) check("tx_back_to_back", st - prev_st, 10 * p);
      end
      prev_st = st;
    end
  endtask

  task automatic rd_rx(input int n);
    int         t;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      while (bus.dv !== 1'b1 && t < LIM) begin
        @(negedge clk);
        t++;
      end
      if (t >= LIM) begin
        n_vec++; n_err++;
        $display("FAIL rx_dv: got timeout, expected dv=1");
        return;
      end
      e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'hxx;
      check("rx_q", bus.q, e);
      check("rx_fe", bus.fe, 1'b0);
      check("rx_ove", bus.ove, 1'b0);
      bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
      check("rx_dv_after_rd", bus.dv, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int p);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (p) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd_drv = b[k];
      repeat (p) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (p) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t;
    int         thre_t;
    logic [31:0] w;
    logic [7:0]  rb;
    bit          rs;
    int          dv_div;
    bit          bm;

    tbl[0] = '{8'h5A, 1'b0, 8'h5A, 1'b1};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[3] = '{8'hA5, 1'b0, 8'hA5, 1'b1};
    tbl[4] = '{8'h81, 1'b1, 8'h81, 1'b0};

    bus.d = '0; bus.wrtx = 1'b0; bus.wrbaud = 1'b0; bus.rd = 1'b0;
    resetb = 1'b0; lb = 1'b1; rxd_drv = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_thre", bus.thre, 1'b1);
    check("rst_tend", bus.tend, 1'b1);
    check("rst_q", bus.q, 8'h00);
    check("rst_dv", bus.dv, 1'b0);
    check("rst_fe", bus.fe, 1'b0);
    check("rst_ove", bus.ove, 1'b0);
    resetb = 1'b1;

    // Normal mode, divider 7, loopback of a single byte
    write_cfg(32'h0000_0007);
    fork
      mon_tx(1);
      rd_rx(1);
      write_tx(32'h0000_0041);
    join

    // Mode change mid-frame, then a burst word back-to-back behind it
    fork
      mon_tx(5);
      rd_rx(5);
      begin
        write_tx(32'h0000_0042);
        repeat (20) @(negedge clk);
        write_cfg(32'h8000_0007);
        write_tx(32'h616C_6F68);
      end
    join

    // Burst thre/tend timing; a write while thre=0 must be dropped
    w = $urandom;
    fork
      mon_tx(4);
      rd_rx(4);
      begin
        @(negedge clk);
        bus.d = w; bus.wrtx = 1'b1;
        push_word(w, 1'b1);
        @(negedge clk);
        check("thre_after_write", bus.thre, 1'b0);
        bus.d = 32'hDEAD_BEEF;
        t = 0; thre_t = -1;
        while (bus.tend !== 1'b1 && t < 3000) begin
          if (bus.thre === 1'b1 && thre_t < 0) thre_t = t;
          t++;
          @(negedge clk);
          bus.wrtx = 1'b0;
        end
        check_range("burst_thre_low", thre_t, 30 * 8, 30 * 8 + 2);
        check_range("burst_tend_low", t, 40 * 8, 40 * 8 + 2);
        repeat (3 * 8) @(negedge clk);
        check("tend_stays_idle", bus.tend, 1'b1);
      end
    join

    // Randomized TX words through loopback
    for (int i = 0; i < 4; i++) begin
      dv_div = $urandom_range(3, 9);
      bm     = 1'($urandom_range(0, 1));
      w      = $urandom;
      write_cfg({bm, 15'd0, 16'(dv_div)});
      fork
        mon_tx(bm ? 4 : 1);
        rd_rx(bm ? 4 : 1);
        write_tx(w);
      join
    end
    check("tx_queue_empty", tx_exp.size(), 0);

    // Overrun with bench-driven rxd
    lb = 1'b0;
    write_cfg(32'h0000_0007);
    send_frame(8'h11, 1'b1, 8);
    send_frame(8'h22, 1'b1, 8);
    check("ovr_q", bus.q, 8'h22);
    check("ovr_dv", bus.dv, 1'b1);
    check("ovr_ove", bus.ove, 1'b1);
    check("ovr_fe", bus.fe, 1'b0);
    pulse_rd();
    check("ovr_dv_clr", bus.dv, 1'b0);
    check("ovr_ove_clr", bus.ove, 1'b0);
    check("ovr_fe_clr", bus.fe, 1'b0);

    // Table-driven RX frames, including bad stop bits
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].b, tbl[i].stop, 8);
      check("tbl_dv", bus.dv, 1'b1);
      check("tbl_q", bus.q, tbl[i].exp_q);
      check("tbl_fe", bus.fe, tbl[i].exp_fe);
      check("tbl_ove", bus.ove, 1'b0);
      pulse_rd();
      check("tbl_dv_clr", bus.dv, 1'b0);
      repeat (8) @(negedge clk);
    end

    // Randomized RX frames at random dividers
    for (int i = 0; i < 6; i++) begin
      dv_div = $urandom_range(3, 12);
      rb     = 8'($urandom);
      rs     = 1'($urandom_range(0, 1));
      write_cfg({16'd0, 16'(dv_div)});
      send_frame(rb, rs, dv_div + 1);
      check("rnd_dv", bus.dv, 1'b1);
      check("rnd_q", bus.q, rb);
      check("rnd_fe", bus.fe, !rs);
      pulse_rd();
      repeat (dv_div + 1) @(negedge clk);
    end

    // Reset in the middle of a burst, then recover in normal mode
    lb = 1'b1;
    write_cfg(32'h8000_0007);
    @(negedge clk);
    bus.d = 32'hC3B2_A190; bus.wrtx = 1'b1;
    @(negedge clk);
    bus.wrtx = 1'b0;
    repeat (12 * 8) @(negedge clk);
    check("midburst_thre", bus.thre, 1'b0);
    resetb = 1'b0;
    @(negedge clk);
    check("rstb_txd", txd, 1'b1);
    check("rstb_thre", bus.thre, 1'b1);
    check("rstb_tend", bus.tend, 1'b1);
    check("rstb_dv", bus.dv, 1'b0);
    resetb = 1'b1;
    write_cfg(32'h0000_0007);
    fork
      mon_tx(1);
      rd_rx(1);
      write_tx(32'h0000_005A);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
